muldiv_sched: RTL and testbench



---
 rtl/muldiv_sched_if.sv | 34 +++
 rtl/muldiv_sched.sv | 161 ++++++++++++++++
 tb/tb_muldiv_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// Bundle of EX-side operation inputs, multiplier/divider handshakes and the HI/LO write bus.
// The sequencer is the slave; the EX stage and the arithmetic units together form the master.
interface muldiv_sched_if;
  logic        op_valid;
  logic [5:0]  op_sel;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        annul;
  logic        stallreq;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic [65:0] hilo_bus;

  modport master (
    output op_valid, op_sel, src1, src2, annul, mul_result, div_result, div_ready,
    input  stallreq, mul_signed, mul_ina, mul_inb, div_start, div_signed,
           div_opdata1, div_opdata2, div_annul, hilo_bus
  );

  modport slave (
    input  op_valid, op_sel, src1, src2, annul, mul_result, div_result, div_ready,
    output stallreq, mul_signed, mul_ina, mul_inb, div_start, div_signed,
           div_opdata1, div_opdata2, div_annul, hilo_bus
  );
endinterface

// File: rtl/muldiv_sched.sv
// EX-stage multiply/divide sequencer: stalls the pipe while the multiplier or the
// iterative divider works, then emits a single-cycle HI/LO write.
module muldiv_sched #(
  parameter int MUL_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  muldiv_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [63:0]      res, res_nx;
  logic             signed_q, signed_nx;
  logic [31:0]      opa, opa_nx;
  logic [31:0]      opb, opb_nx;

  logic sel_div, sel_mul, sel_hi, sel_lo, sel_signed;
  logic stall, div_go, div_kill;
  logic hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  // Priority decode of op_sel: div > divu > mult > multu > mthi > mtlo
  always_comb begin
    sel_div    = 1'b0;
    sel_mul    = 1'b0;
    sel_hi     = 1'b0;
    sel_lo     = 1'b0;
    sel_signed = 1'b0;
    if (bus.op_sel[5]) begin
      sel_div    = 1'b1;
      sel_signed = 1'b1;
    end else if (bus.op_sel[4]) begin
      sel_div = 1'b1;
    end else if (bus.op_sel[3]) begin
      sel_mul    = 1'b1;
      sel_signed = 1'b1;
    end else if (bus.op_sel[2]) begin
      sel_mul = 1'b1;
    end else if (bus.op_sel[1]) begin
      sel_hi = 1'b1;
    end else if (bus.op_sel[0]) begin
      sel_lo = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      res      <= '0;
      signed_q <= 1'b0;
      opa      <= '0;
      opb      <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      res      <= res_nx;
      signed_q <= signed_nx;
      opa      <= opa_nx;
      opb      <= opb_nx;
    end
  end

  // Accept is gated by rst so every output reads zero while reset is held
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    res_nx    = res;
    signed_nx = signed_q;
    opa_nx    = opa;
    opb_nx    = opb;
    stall     = 1'b0;
    div_go    = 1'b0;
    div_kill  = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_wdata  = '0;
    lo_wdata  = '0;
    case (state)
      IDLE: begin
        if (bus.op_valid && !rst && !bus.annul) begin
          if (sel_mul || sel_div) begin
            stall     = 1'b1;
            signed_nx = sel_signed;
            opa_nx    = bus.src1;
            opb_nx    = bus.src2;
            if (sel_mul) begin
              state_nx = MUL_WAIT;
              cnt_nx   = CNT_W'(MUL_LAT - 1);
            end else if (bus.src2 != 32'd0) begin
              state_nx = DIV_WAIT;
            end else begin
              res_nx   = {bus.src1, 32'hFFFF_FFFF};
              state_nx = DONE;
            end
          end else if (sel_hi) begin
            hi_we    = 1'b1;
            hi_wdata = bus.src1;
          end else if (sel_lo) begin
            lo_we    = 1'b1;
            lo_wdata = bus.src1;
          end
        end
      end
      MUL_WAIT: begin
        if (bus.annul) begin
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt == '0) begin
            res_nx   = bus.mul_result;
            state_nx = DONE;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
      end
      DIV_WAIT: begin
        if (bus.annul) begin
          div_kill = 1'b1;
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
          if (bus.div_ready) begin
            res_nx   = bus.div_result;
            state_nx = DONE;
          end else begin
            div_go = 1'b1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (!bus.annul) begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          hi_wdata = res[63:32];
          lo_wdata = res[31:0];
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.stallreq    = stall;
  assign bus.mul_signed  = signed_q && (state == MUL_WAIT);
  assign bus.mul_ina     = opa;
  assign bus.mul_inb     = opb;
  assign bus.div_start   = div_go;
  assign bus.div_signed  = signed_q && (state == DIV_WAIT);
  assign bus.div_opdata1 = opa;
  assign bus.div_opdata2 = opb;
  assign bus.div_annul   = div_kill;
  assign bus.hilo_bus    = {hi_we, lo_we, hi_wdata, lo_wdata};

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: two instances (MUL_LAT 1 and 4), a
// multiplier/divider model, and a scoreboard of expected HI/LO writes.
module tb_muldiv_sched;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  muldiv_sched_if bus1 ();
  muldiv_sched_if bus4 ();

  muldiv_sched #(.MUL_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  muldiv_sched #(.MUL_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic [65:0] q1[$];
  logic [65:0] q4[$];
  logic [65:0] exp1, exp4;
  logic [198:0] outs1, outs4;
  int dcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] uq, ur;
    sa = a;
    sb = b;
    if (s) begin
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  assign bus1.mul_result = mul_model(bus1.mul_signed, bus1.mul_ina, bus1.mul_inb);
  assign bus4.mul_result = mul_model(bus4.mul_signed, bus4.mul_ina, bus4.mul_inb);
  assign bus4.div_ready  = 1'b0;
  assign bus4.div_result = 64'd0;

  assign outs1 = {bus1.stallreq, bus1.mul_signed, bus1.mul_ina, bus1.mul_inb, bus1.div_start,
                  bus1.div_signed, bus1.div_opdata1, bus1.div_opdata2, bus1.div_annul, bus1.hilo_bus};
  assign outs4 = {bus4.stallreq, bus4.mul_signed, bus4.mul_ina, bus4.mul_inb, bus4.div_start,
                  bus4.div_signed, bus4.div_opdata1, bus4.div_opdata2, bus4.div_annul, bus4.hilo_bus};

  // Iterative divider: ready after div_start has been held for 32 cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt              <= 0;
      bus1.div_ready    <= 1'b0;
      bus1.div_result   <= 64'd0;
    end else begin
      bus1.div_ready <= 1'b0;
      if (bus1.div_annul) begin
        dcnt <= 0;
      end else if (bus1.div_start) begin
        if (dcnt == 31) begin
          dcnt            <= 0;
          bus1.div_ready  <= 1'b1;
          bus1.div_result <= div_model(bus1.div_signed, bus1.div_opdata1, bus1.div_opdata2);
        end else begin
          dcnt <= dcnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.hilo_bus !== 66'd0) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("[TB] FAIL hilo1_unexpected got=%h want=no write", bus1.hilo_bus);
      end else begin
        exp1 = q1.pop_front();
        if (bus1.hilo_bus !== exp1) begin
          fails++;
          $display("[TB] FAIL hilo1 got=%h want=%h", bus1.hilo_bus, exp1);
        end
      end
    end
    if (bus4.hilo_bus !== 66'd0) begin
      tests++;
      if (q4.size() == 0) begin
        fails++;
        $display("[TB] FAIL hilo4_unexpected got=%h want=no write", bus4.hilo_bus);
      end else begin
        exp4 = q4.pop_front();
        if (bus4.hilo_bus !== exp4) begin
          fails++;
          $display("[TB] FAIL hilo4 got=%h want=%h", bus4.hilo_bus, exp4);
        end
      end
    end
  end

  // Issues one op on bus1 and counts stall and div_start cycles up to the DONE/no-stall cycle
  task automatic run_op(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int starts);
    bit done;
    stalls = 0;
    starts = 0;
    done   = 1'b0;
    @(posedge clk); #1;
    bus1.op_valid = 1'b1;
    bus1.op_sel   = sel;
    bus1.src1     = a;
    bus1.src2     = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus1.div_start === 1'b1) starts++;
      if (bus1.stallreq !== 1'b1) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    if (!done) stalls = -1;
  endtask

  task automatic go_idle;
    @(posedge clk); #1;
    bus1.op_valid = 1'b0;
    bus1.op_sel   = 6'd0;
    bus1.annul    = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if (outs1 !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outs1 got=%h want=0", outs1);
    end
    tests++;
    if (outs4 !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outs4 got=%h want=0", outs4);
    end
    #9 rst = 1'b0;
  endtask

  task automatic test_signed_mult;
    int st, sd;
    q1.push_back({2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op(6'b001000, 32'hFFFF_FFFD, 32'd5, st, sd);
    tests++;
    if (st !== 2) begin
      fails++;
      $display("[TB] FAIL mult_stalls got=%0d want=2", st);
    end
    go_idle();
  endtask

  task automatic test_unsigned_div;
    int st, sd;
    q1.push_back({2'b11, 32'd2, 32'd14});
    run_op(6'b010000, 32'd100, 32'd7, st, sd);
    tests++;
    if (st !== 34) begin
      fails++;
      $display("[TB] FAIL divu_stalls got=%0d want=34", st);
    end
    tests++;
    if (sd !== 32) begin
      fails++;
      $display("[TB] FAIL divu_starts got=%0d want=32", sd);
    end
    go_idle();
  endtask

  task automatic test_div_zero;
    int st, sd;
    q1.push_back({2'b11, 32'h0000_1234, 32'hFFFF_FFFF});
    run_op(6'b100000, 32'h0000_1234, 32'd0, st, sd);
    tests++;
    if (st !== 1) begin
      fails++;
      $display("[TB] FAIL div0_stalls got=%0d want=1", st);
    end
    tests++;
    if (sd !== 0) begin
      fails++;
      $display("[TB] FAIL div0_starts got=%0d want=0", sd);
    end
    go_idle();
  endtask

  task automatic test_priority;
    int st, sd;
    q1.push_back({2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(6'b110001, 32'hFFFF_FFF9, 32'd2, st, sd);
    tests++;
    if (st !== 34 || sd !== 32) begin
      fails++;
      $display("[TB] FAIL prio_div_timing got=%0d/%0d want=34/32", st, sd);
    end
    go_idle();
  endtask

  task automatic test_flush_div;
    int pulses, stalls;
    @(posedge clk); #1;
    bus1.op_valid = 1'b1;
    bus1.op_sel   = 6'b100000;
    bus1.src1     = 32'd50;
    bus1.src2     = 32'd3;
    repeat (10) @(posedge clk);
    #1 bus1.annul = 1'b1;
    @(negedge clk);
    tests++;
    if (bus1.div_annul !== 1'b1 || bus1.stallreq !== 1'b0 || bus1.div_start !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_cycle got=annul%b stall%b start%b want=annul1 stall0 start0",
               bus1.div_annul, bus1.stallreq, bus1.div_start);
    end
    q1.push_back({2'b01, 32'd0, 32'h0000_CAFE});
    @(posedge clk); #1;
    bus1.annul  = 1'b0;
    bus1.op_sel = 6'b000001;
    bus1.src1   = 32'h0000_CAFE;
    @(negedge clk);
    tests++;
    if (bus1.stallreq !== 1'b0 || bus1.div_annul !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_next_idle got=stall%b annul%b want=stall0 annul0",
               bus1.stallreq, bus1.div_annul);
    end
    go_idle();
    pulses = 0;
    stalls = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.div_annul !== 1'b0) pulses++;
      if (bus1.stallreq !== 1'b0) stalls++;
    end
    tests++;
    if (pulses !== 0 || stalls !== 0) begin
      fails++;
      $display("[TB] FAIL flush_quiet got=annul%0d stall%0d want=0/0", pulses, stalls);
    end
  endtask

  task automatic test_back_to_back;
    int st, sd;
    q1.push_back({2'b10, 32'hA5A5_0000, 32'd0});
    run_op(6'b000010, 32'hA5A5_0000, 32'd0, st, sd);
    tests++;
    if (st !== 0) begin
      fails++;
      $display("[TB] FAIL mthi_stalls got=%0d want=0", st);
    end
    q1.push_back({2'b11, 32'h0000_0001, 32'hFFFF_FFFE});
    run_op(6'b000100, 32'hFFFF_FFFF, 32'd2, st, sd);
    tests++;
    if (st !== 2) begin
      fails++;
      $display("[TB] FAIL multu_b2b_stalls got=%0d want=2", st);
    end
    go_idle();
  endtask

  task automatic test_annul_write;
    @(posedge clk); #1;
    bus1.op_valid = 1'b1;
    bus1.op_sel   = 6'b000010;
    bus1.src1     = 32'h1111_2222;
    bus1.annul    = 1'b1;
    @(negedge clk);
    tests++;
    if (bus1.hilo_bus !== 66'd0) begin
      fails++;
      $display("[TB] FAIL annul_mthi got=%h want=0", bus1.hilo_bus);
    end
    @(posedge clk); #1;
    bus1.annul  = 1'b0;
    bus1.op_sel = 6'b001000;
    bus1.src1   = 32'd3;
    bus1.src2   = 32'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus1.annul = 1'b1;
    @(negedge clk);
    tests++;
    if (bus1.hilo_bus !== 66'd0 || bus1.stallreq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL annul_done got=%h stall%b want=0 stall0", bus1.hilo_bus, bus1.stallreq);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_mult;
    int st;
    bit done;
    @(posedge clk); #1;
    bus4.op_valid = 1'b1;
    bus4.op_sel   = 6'b001000;
    bus4.src1     = 32'd7;
    bus4.src2     = 32'd6;
    @(posedge clk); #1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus4.stallreq !== 1'b1 || bus4.mul_signed !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mul4_busy got=stall%b signed%b want=1/1", bus4.stallreq, bus4.mul_signed);
    end
    #1;
    rst           = 1'b1;
    bus4.op_valid = 1'b0;
    #1;
    tests++;
    if (outs4 !== '0) begin
      fails++;
      $display("[TB] FAIL async_reset got=%h want=0", outs4);
    end
    #1 rst = 1'b0;
    q4.push_back({2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    @(posedge clk); #1;
    bus4.op_valid = 1'b1;
    bus4.src1     = 32'hFFFF_FFFE;
    bus4.src2     = 32'd3;
    st   = 0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus4.stallreq !== 1'b1) done = 1'b1;
      else begin
        st++;
        @(posedge clk); #1;
      end
    end
    tests++;
    if (!done || st !== 5) begin
      fails++;
      $display("[TB] FAIL mul4_stalls got=%0d want=5", done ? st : -1);
    end
    @(posedge clk); #1;
    bus4.op_valid = 1'b0;
  endtask

  task automatic test_drain;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (q1.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain1 got=%0d pending want=0", q1.size());
    end
    tests++;
    if (q4.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain4 got=%0d pending want=0", q4.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    bus1.op_valid = 1'b0;
    bus1.op_sel   = 6'd0;
    bus1.src1     = 32'd0;
    bus1.src2     = 32'd0;
    bus1.annul    = 1'b0;
    bus4.op_valid = 1'b0;
    bus4.op_sel   = 6'd0;
    bus4.src1     = 32'd0;
    bus4.src2     = 32'd0;
    bus4.annul    = 1'b0;
    test_reset();
    test_signed_mult();
    test_unsigned_div();
    test_div_zero();
    test_priority();
    test_flush_div();
    test_back_to_back();
    test_annul_write();
    test_reset_mid_mult();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
